store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Sits between the processor memory-access stage and data_mem.
- Absorbs stores into a small in-order FIFO so the pipeline does not stall on every write, then drains the FIFO to data_mem through data_mem's stall handshake.
- Loads are issued to data_mem directly. A load that hits a pending store forces a drain first. Optionally, an exact word match is forwarded.

Parameters:
- DEPTH, 4, number of store entries; power of 2, minimum 2.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  32  byte address from the pipeline
- cpu_write_data  in  32  store data
- cpu_memwrite  in  1  store request; held while cpu_stall=1
- cpu_memread  in  1  load request; held while cpu_stall=1
- cpu_sign_mask  in  4  [3] sign-extend, [2] word, [1] halfword, else byte
- cpu_read_data  out  32  load result; valid in the cycle cpu_stall falls for a load
- cpu_stall  out  1  pipeline hold
- mem_addr  out  32  to data_mem addr
- mem_write_data  out  32  to data_mem write_data
- mem_memwrite  out  1  to data_mem memwrite
- mem_memread  out  1  to data_mem memread
- mem_sign_mask  out  4  to data_mem sign_mask
- mem_read_data  in  32  from data_mem read_data
- mem_stall  in  1  from data_mem clk_stall

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state IDLE; all outputs 0. A reset mid-transaction abandons it; any store in flight may or may not have landed.
- FIFO entry = {addr, write_data, sign_mask}. Head and tail pointers wrap modulo DEPTH. count is 0..DEPTH.
- Store accept: cpu_memwrite=1 and (count<DEPTH, or a drain completes this cycle) -> enqueue on the clock edge. cpu_stall=0 for that cycle.
- FIFO full with no completion this cycle -> cpu_stall=1 combinationally.
- Simultaneous enqueue and dequeue at full leaves count unchanged.
- Load hit: word address cpu_addr[31:2] equals any valid entry's addr[31:2].
- Load on hit -> cpu_stall=1; drain until no matching entry remains, then issue the load.
- Load with no hit -> issued at the next transaction boundary, ahead of remaining stores; loads take priority over drain.
- Load completion: mem_read_data is captured into cpu_read_data when the load's DONE occurs. cpu_stall drops in the following cycle, and cpu_read_data is held until the next load completes.
- Downstream FSM:
  - IDLE: a pending load or a non-empty FIFO -> ISSUE. Otherwise mem_memread=mem_memwrite=0.
  - ISSUE: drive mem_* with the selected request -> WAIT_ACK.
  - WAIT_ACK: hold mem_*; mem_stall=1 -> WAIT_DONE.
  - WAIT_DONE: hold mem_*; mem_stall=0 -> DONE event (dequeue the head, or complete the load) -> GAP.
  - GAP: one cycle with mem_memread=mem_memwrite=0 so that identical consecutive requests appear as an input change downstream -> IDLE.
- Minimum store drain cost is therefore 5 cycles per entry (data_mem latency-dependent).
- mem_* outputs are registered and change only in ISSUE and GAP.
- Stores are never merged; order among stores is preserved.
- cpu_memread and cpu_memwrite both high is illegal. The block treats it as a store.

Optional Feature:
- STORE_BUF_FWD_EN defined: a load that hits, where both the load and the newest matching entry are word accesses (sign_mask[2]=1) with addr[1:0]=0, returns that entry's data.
  - cpu_read_data is updated on the edge; cpu_stall=0 in the request cycle; no downstream access and no drain.
- Any other hit drains as above.
- Not defined: every hit drains.

Test Plan:
1. Reset with rst_n low mid-WAIT_DONE -> all outputs 0 immediately; count=0. After release, the first store to 0x1000 issues cleanly.
2. Four back-to-back word stores 0x1000..0x100C, data 0xA0..0xA3, with data_mem model -> cpu_stall=0 on all four. A fifth store stalls until the first DONE. Memory ends with 0xA0..0xA4 in order.
3. Store word 0xDEADBEEF @0x1010, then load byte signed (mask 4'b1000) @0x1013 -> drain first; cpu_read_data=0xFFFFFFDE.
4. Store @0x1020 pending, load @0x1040 -> load issued before the store drains; cpu_read_data equals the preloaded memory word.
5. Two identical stores 0x55 @0x1030 -> a GAP cycle is seen between them on mem_memwrite; both complete.
6. STORE_BUF_FWD_EN: store word 0x12345678 @0x1050, load word @0x1050 -> cpu_read_data=0x12345678 with no stall and no mem_memread pulse. Without the macro: drain, then the same value.

Source files
------------

// File: rtl/store_buffer.sv
// In-order store FIFO between the memory-access stage and data_mem; loads bypass pending stores
// unless they hit one. Define STORE_BUF_FWD_EN to forward exact word hits without draining.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_write_data,
  input  logic              cpu_memwrite,
  input  logic              cpu_memread,
  input  logic [3:0]        cpu_sign_mask,
  output logic [31:0]       cpu_read_data,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_stall
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [31:0]       q_data [DEPTH];
  logic [3:0]        q_mask [DEPTH];
  logic [DEPTH-1:0]  q_vld;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic              cur_load, rd_done;

  logic        full, deq, ld_done, enq, load_raw, load_req, hit, fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;
  logic [1:0]  fwd_alo;
  logic [PW-1:0] idx;

  assign full     = (count == CW'(DEPTH));
  assign deq      = (state == WAIT_DONE) && !mem_stall && !cur_load;
  assign ld_done  = (state == WAIT_DONE) && !mem_stall &&  cur_load;
  assign enq      = cpu_memwrite && (!full || deq);
  // rd_done masks the already-completed load still held on the inputs for one cycle
  assign load_raw = cpu_memread && !cpu_memwrite && !rd_done;

  // Valid entries are contiguous from head, so the last match found is the newest one
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    fwd_mask = '0;
    fwd_alo  = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (q_vld[idx] && (q_addr[idx][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])) begin
        hit      = 1'b1;
        fwd_data = q_data[idx];
        fwd_mask = q_mask[idx];
        fwd_alo  = q_addr[idx][1:0];
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign fwd_hit = load_raw && hit && cpu_sign_mask[2] && (cpu_addr[1:0] == 2'b00) &&
                   fwd_mask[2] && (fwd_alo == 2'b00);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_data, fwd_mask, fwd_alo};
  assign fwd_hit    = 1'b0;
`endif

  assign load_req  = load_raw && !fwd_hit;
  assign cpu_stall = rst_n && ((cpu_memwrite && full && !deq) || load_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (load_req || (count != '0)) state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_ACK;
      WAIT_ACK:  if (mem_stall) state_nx = WAIT_DONE;
      WAIT_DONE: if (!mem_stall) state_nx = GAP;
      GAP:       state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
    end else begin
      if (deq) begin
        q_vld[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      // at full, enqueue reuses the slot being freed, so the set must follow the clear
      if (enq) begin
        q_vld[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[tail] <= cpu_addr;
      q_data[tail] <= cpu_write_data;
      q_mask[tail] <= cpu_sign_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_read_data  <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= '0;
      cur_load       <= 1'b0;
      rd_done        <= 1'b0;
    end else begin
      rd_done <= ld_done;
      if (ld_done)      cpu_read_data <= mem_read_data;
      else if (fwd_hit) cpu_read_data <= fwd_data;
      if (state == ISSUE) begin
        // a non-hitting load overtakes queued stores; a hitting load waits for the drain
        if (load_req && !hit) begin
          mem_addr       <= cpu_addr;
          mem_write_data <= '0;
          mem_sign_mask  <= cpu_sign_mask;
          mem_memread    <= 1'b1;
          mem_memwrite   <= 1'b0;
          cur_load       <= 1'b1;
        end else begin
          mem_addr       <= q_addr[head];
          mem_write_data <= q_data[head];
          mem_sign_mask  <= q_mask[head];
          mem_memread    <= 1'b0;
          mem_memwrite   <= 1'b1;
          cur_load       <= 1'b0;
        end
      end else if (state == GAP) begin
        mem_memread  <= 1'b0;
        mem_memwrite <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a stalling data_mem model and write/load scoreboards.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cpu_addr = '0, cpu_write_data = '0;
  logic        cpu_memwrite = 1'b0, cpu_memread = 1'b0;
  logic [3:0]  cpu_sign_mask = '0;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_addr, mem_write_data;
  logic        mem_memwrite, mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = '0;
  logic        mem_stall = 1'b0;

  int n_cmp = 0, n_bad = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_sign_mask(cpu_sign_mask), .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data), .mem_stall(mem_stall)
  );

  // ---------------- data_mem model ----------------
  localparam int LAT = 2;
  logic [31:0] mem [logic [29:0]];
  logic        busy = 1'b0, served = 1'b0;
  int          cnt = 0;
  logic [31:0] r_addr = '0, r_data = '0;
  logic        r_rd = 1'b0;
  logic [3:0]  r_mask = '0;
  logic        wr_evt = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [1:0] off, input logic [3:0] m);
    logic [31:0] t;
    logic [7:0]  b;
    logic [15:0] h;
    t = w >> (int'(off) * 8);
    b = t[7:0];
    h = off[1] ? w[31:16] : w[15:0];
    if (m[2]) return w;
    if (m[1]) return m[3] ? {{16{h[15]}}, h} : {16'h0, h};
    return m[3] ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [1:0] off, input logic [3:0] m);
    logic [31:0] r;
    int sh;
    r  = old;
    sh = int'(off) * 8;
    if (m[2]) r = d;
    else if (m[1]) begin
      if (off[1]) r[31:16] = d[15:0];
      else        r[15:0]  = d[15:0];
    end else r[sh +: 8] = d[7:0];
    return r;
  endfunction

  always @(posedge clk) begin
    wr_evt <= 1'b0;
    if (!(mem_memread || mem_memwrite)) served <= 1'b0;
    if (busy) begin
      if (cnt == 0) begin
        busy      <= 1'b0;
        mem_stall <= 1'b0;
        served    <= 1'b1;
        if (r_rd) mem_read_data <= ld_fmt(rd_word(r_addr), r_addr[1:0], r_mask);
        else begin
          mem[r_addr[31:2]] = st_merge(rd_word(r_addr), r_data, r_addr[1:0], r_mask);
          wr_evt  <= 1'b1;
          wr_addr <= r_addr;
          wr_data <= r_data;
        end
      end else cnt <= cnt - 1;
    end else if ((mem_memread || mem_memwrite) && !served) begin
      busy      <= 1'b1;
      mem_stall <= 1'b1;
      cnt       <= LAT;
      r_addr    <= mem_addr;
      r_data    <= mem_write_data;
      r_rd      <= mem_memread && !mem_memwrite;
      r_mask    <= mem_sign_mask;
    end
  end

  // ---------------- scoreboards / monitors ----------------
  logic [63:0] exp_wr [$];
  logic [31:0] exp_ld [$];
  logic        ignore_wr = 1'b0;
  int          wr_count = 0, rise_wr = 0, rise_rd = 0;
  logic        prev_wr = 1'b0, prev_rd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mem_memwrite && !prev_wr) rise_wr++;
    if (mem_memread && !prev_rd) rise_rd++;
    prev_wr = mem_memwrite;
    prev_rd = mem_memread;
    if (wr_evt) begin
      wr_count++;
      if (!ignore_wr) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wr_unexpected: got %h:%h expected none", wr_addr, wr_data);
        end else chk("wr_order", {wr_addr, wr_data} == exp_wr.pop_front() ? 32'd1 : 32'd0, 32'd1);
      end
    end
  end

  initial forever begin
    logic acc;
    @(negedge clk);
    acc = rst_n && cpu_memread && !cpu_memwrite && !cpu_stall;
    if (acc) begin
      @(posedge clk); #2;
      if (exp_ld.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ld_unexpected: got %h expected none", cpu_read_data);
      end else chk("ld_data", cpu_read_data, exp_ld.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] m, output int stalls);
    cpu_memwrite = wr; cpu_memread = rd; cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m;
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
    end
    if (stalls >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL op_timeout: got stall>=300 cycles expected release");
    end
    @(posedge clk); #1;
    cpu_memwrite = 1'b0; cpu_memread = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, output int s);
    exp_wr.push_back({a, d});
    op(1'b1, 1'b0, a, d, 4'b0100, s);
  endtask

  task automatic ld(input logic [31:0] a, input logic [3:0] m, input logic [31:0] e, output int s);
    exp_ld.push_back(e);
    op(1'b0, 1'b1, a, 32'h0, m, s);
  endtask

  initial begin
    int s, w0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset during WAIT_DONE
    ignore_wr = 1'b1;
    op(1'b1, 1'b0, 32'h2000, 32'h99, 4'b0100, s);
    s = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_stall) break;
      s++;
    end
    chk("t1_stall_seen", {31'h0, mem_stall}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t1_cpu_stall", {31'h0, cpu_stall}, 32'd0);
    chk("t1_memwrite", {31'h0, mem_memwrite}, 32'd0);
    chk("t1_memread", {31'h0, mem_memread}, 32'd0);
    chk("t1_mem_addr", mem_addr, 32'h0);
    chk("t1_mem_wdata", mem_write_data, 32'h0);
    chk("t1_mem_mask", {28'h0, mem_sign_mask}, 32'h0);
    chk("t1_rdata", cpu_read_data, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 ignore_wr = 1'b0;

    // 2: fill FIFO, fifth store stalls, drain order
    for (int i = 0; i < 4; i++) begin
      st(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), s);
      chk("t2_no_stall", s, 32'd0);
    end
    st(32'h1010, 32'hA4, s);
    chk("t2_fifth_stalls", (s > 0) ? 32'd1 : 32'd0, 32'd1);
    repeat (60) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) chk("t2_mem", rd_word(32'h1000 + 32'(4 * i)), 32'hA0 + 32'(i));

    // 3: load hit forces drain, signed byte
    st(32'h1010, 32'hDEADBEEF, s);
    ld(32'h1013, 4'b1000, 32'hFFFFFFDE, s);
    repeat (20) @(posedge clk);
    #1;

    // 4: non-hitting load overtakes pending store
    mem[30'h410] = 32'hCAFEF00D;
    w0 = wr_count;
    st(32'h1020, 32'h77, s);
    ld(32'h1040, 4'b0100, 32'hCAFEF00D, s);
    chk("t4_load_first", wr_count, w0);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_store_after", wr_count, w0 + 1);

    // 5: identical stores separated by a GAP
    rise_wr = 0;
    st(32'h1030, 32'h55, s);
    st(32'h1030, 32'h55, s);
    repeat (30) @(posedge clk);
    #1;
    chk("t5_two_pulses", rise_wr, 32'd2);

    // 6: word hit -- forwarded or drained
    st(32'h1050, 32'h12345678, s);
    rise_rd = 0;
    ld(32'h1050, 4'b0100, 32'h12345678, s);
`ifdef STORE_BUF_FWD_EN
    chk("t6_fwd_no_stall", s, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_fwd_no_memread", rise_rd, 32'd0);
`else
    chk("t6_drain_stalls", (s > 0) ? 32'd1 : 32'd0, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_one_memread", rise_rd, 32'd1);
`endif

    repeat (20) @(posedge clk);
    #1;
    chk("end_wr_queue_empty", exp_wr.size(), 32'd0);
    chk("end_ld_queue_empty", exp_ld.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
